// File: rtl/mypc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mypc_pkg
// Description : Shared types and constants for the mypc fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mypc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_XCHG = 4'd2;
  localparam logic [3:0] c_OP_RCL  = 4'd3;
  localparam logic [3:0] c_OP_SHR  = 4'd4;
  localparam logic [3:0] c_OP_MOV  = 4'd5;
  localparam logic [3:0] c_OP_XOR  = 4'd6;
  localparam logic [3:0] c_OP_AND  = 4'd7;
  localparam logic [3:0] c_OP_OR   = 4'd8;
  localparam logic [3:0] c_OP_OUT  = 4'd9;
  localparam logic [3:0] c_OP_JZ   = 4'd10;
  localparam logic [3:0] c_OP_PUSH = 4'd11;
  localparam logic [3:0] c_OP_POP  = 4'd12;
  localparam logic [3:0] c_OP_CALL = 4'd13;
  localparam logic [3:0] c_OP_RET  = 4'd14;
  localparam logic [3:0] c_OP_HLT  = 4'd15;

  // Field position within a program word, in units of DW bits
  localparam int c_FLD_OPC = 2;
  localparam int c_FLD_A   = 1;
  localparam int c_FLD_B   = 0;

endpackage
`default_nettype wire

// File: rtl/mypc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mypc_fetch_unit_if
// Description : Host/core-facing signal bundle of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mypc_fetch_unit_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [3*DW-1:0] load_data;
  logic            start;
  logic            hold;
  logic            redirect_en;
  logic [AW-1:0]   redirect_addr;
  logic            stop_flag;
  logic [DW-1:0]   pc_instr;
  logic [DW-1:0]   A;
  logic [DW-1:0]   B;
  logic            instr_valid;
  logic [AW-1:0]   fetch_pc;
  logic            running;
  logic            halted;

  modport master (
    output load_en, load_addr, load_data, start, hold,
           redirect_en, redirect_addr, stop_flag,
    input  pc_instr, A, B, instr_valid, fetch_pc, running, halted
  );

  modport slave (
    input  load_en, load_addr, load_data, start, hold,
           redirect_en, redirect_addr, stop_flag,
    output pc_instr, A, B, instr_valid, fetch_pc, running, halted
  );
endinterface
`default_nettype wire

// File: rtl/mypc_prog_ram.sv
`default_nettype none
// ============================================================================
// Module      : mypc_prog_ram
// Description : Program memory, synchronous write / asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module mypc_prog_ram #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  wire logic            mypc_clock,
  input  wire logic            wr_en,
  input  wire logic [AW-1:0]   wr_addr,
  input  wire logic [3*DW-1:0] wr_data,
  input  wire logic [AW-1:0]   rd_addr,
  output logic      [3*DW-1:0] rd_data
);
  logic [3*DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge mypc_clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];
endmodule
`default_nettype wire

// File: rtl/mypc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : mypc_fetch_unit
// Description : Sequences program memory into the core, honouring halt/redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module mypc_fetch_unit
  import mypc_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input wire logic         mypc_clock,
  input wire logic         mypc_reset,
  mypc_fetch_unit_if.slave bus
);
  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic [AW-1:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [DW-1:0]   r_pc_instr, w_pc_instr_nxt;
  logic [DW-1:0]   r_a, w_a_nxt;
  logic [DW-1:0]   r_b, w_b_nxt;
  logic            r_valid, w_valid_nxt;
  logic [3*DW-1:0] w_rd_data;
  logic            w_wr_en;

  // Program is only writable while nothing is being fetched
  assign w_wr_en = bus.load_en && (r_state != ST_RUN);

  mypc_prog_ram #(.AW(AW), .DW(DW)) u_ram (
    .mypc_clock (mypc_clock),
    .wr_en      (w_wr_en),
    .wr_addr    (bus.load_addr),
    .wr_data    (bus.load_data),
    .rd_addr    (r_pc),
    .rd_data    (w_rd_data)
  );

  always_ff @(posedge mypc_clock or posedge mypc_reset) begin
    if (mypc_reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_fetch_pc <= '0;
      r_pc_instr <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pc_instr <= w_pc_instr_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pc_instr_nxt = r_pc_instr;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_valid_nxt    = r_valid;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          w_pc_nxt    = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop_flag) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_HALT;
        end else if (bus.redirect_en) begin
          w_pc_nxt    = bus.redirect_addr;
          w_valid_nxt = 1'b0;
        end else if (!bus.hold) begin
          w_pc_instr_nxt = w_rd_data[c_FLD_OPC*DW +: DW];
          w_a_nxt        = w_rd_data[c_FLD_A*DW +: DW];
          w_b_nxt        = w_rd_data[c_FLD_B*DW +: DW];
          w_fetch_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.pc_instr    = r_pc_instr;
  assign bus.A           = r_a;
  assign bus.B           = r_b;
  assign bus.fetch_pc    = r_fetch_pc;
  assign bus.instr_valid = r_valid;
  assign bus.running     = (r_state == ST_RUN);
  assign bus.halted      = (r_state == ST_HALT);
endmodule
`default_nettype wire
